// File: rtl/acc_requant_int8_if.sv
`default_nettype none
// ============================================================================
// acc_requant_int8_if : config + sample/result bus of the int8 requant stage
// Revision 1.0
// ============================================================================
interface acc_requant_int8_if #(
    parameter int NUM_CH = 16,
    parameter int ACC_W  = 32,
    parameter int MULT_W = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_addr;
    logic [MULT_W-1:0] cfg_mult;
    logic [4:0]        cfg_shift;
    logic [7:0]        cfg_zp;
    logic              frame_start;
    logic              in_valid;
    logic [ACC_W-1:0]  in_acc;
    logic              out_valid;
    logic [7:0]        out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output cfg_we, cfg_addr, cfg_mult, cfg_shift, cfg_zp,
        output frame_start, in_valid, in_acc,
        input  out_valid, out_data, out_ch
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_mult, cfg_shift, cfg_zp,
        input  frame_start, in_valid, in_acc,
        output out_valid, out_data, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/acc_requant_int8.sv
`default_nettype none
// ============================================================================
// acc_requant_int8 : per-channel multiply / rounding shift / zero-point / int8
// saturation, 3-stage valid-only pipeline.   Revision 1.0
// ============================================================================
module acc_requant_int8 #(
    parameter int NUM_CH = 16,
    parameter int ACC_W  = 32,
    parameter int MULT_W = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire                 clk,
    input  wire                 rst_n,
    acc_requant_int8_if.slave   bus
);
    localparam int PW = ACC_W + MULT_W + 1;
    localparam logic signed [PW:0] C_SAT_MAX = (PW+1)'(127);
    localparam logic signed [PW:0] C_SAT_MIN = -(PW+1)'(128);

    // Parameter file
    logic [MULT_W-1:0] mult_q  [NUM_CH];
    logic [4:0]        shift_q [NUM_CH];
    logic [7:0]        zp_q    [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mult_q[i]  <= MULT_W'(1);
                shift_q[i] <= 5'd0;
                zp_q[i]    <= 8'd0;
            end
        end else if (bus.cfg_we) begin
            // Addresses with no matching entry fall through and are ignored
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cfg_addr == CH_W'(i)) begin
                    mult_q[i]  <= bus.cfg_mult;
                    shift_q[i] <= bus.cfg_shift;
                    zp_q[i]    <= bus.cfg_zp;
                end
            end
        end
    end

    // Channel sequencer
    logic [CH_W-1:0] ch_q, ch_d, w_cur;

    always_comb begin
        w_cur = bus.frame_start ? '0 : ch_q;
        ch_d  = ch_q;
        if (bus.in_valid)
            ch_d = (w_cur == CH_W'(NUM_CH - 1)) ? '0 : w_cur + CH_W'(1);
        else if (bus.frame_start)
            ch_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ch_q <= '0;
        else        ch_q <= ch_d;
    end

    // Stage 1: parameter capture and product
    logic signed [PW-1:0] w_acc_ext, w_mult_ext, w_prod;
    logic                 v1_q;
    logic signed [PW-1:0] prod1_q;
    logic [4:0]           shift1_q;
    logic [7:0]           zp1_q;
    logic [CH_W-1:0]      ch1_q;

    assign w_acc_ext  = {{(PW-ACC_W){bus.in_acc[ACC_W-1]}}, bus.in_acc};
    assign w_mult_ext = {{(PW-MULT_W){1'b0}}, mult_q[w_cur]};
    assign w_prod     = w_acc_ext * w_mult_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            prod1_q  <= '0;
            shift1_q <= 5'd0;
            zp1_q    <= 8'd0;
            ch1_q    <= '0;
        end else begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                prod1_q  <= w_prod;
                shift1_q <= shift_q[w_cur];
                zp1_q    <= zp_q[w_cur];
                ch1_q    <= w_cur;
            end
        end
    end

    // Stage 2: rounding shift (half toward +inf) and zero-point
    logic signed [PW-1:0] w_rnd, w_r;
    logic signed [PW:0]   w_s;
    logic                 v2_q;
    logic signed [PW:0]   s2_q;
    logic [CH_W-1:0]      ch2_q;

    always_comb begin
        w_rnd = '0;
        w_r   = prod1_q;
        if (shift1_q != 5'd0) begin
            w_rnd = PW'(1) << (shift1_q - 5'd1);
            w_r   = (prod1_q + w_rnd) >>> shift1_q;
        end
        w_s = {w_r[PW-1], w_r} + {{(PW-7){zp1_q[7]}}, zp1_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            s2_q  <= '0;
            ch2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_q  <= w_s;
                ch2_q <= ch1_q;
            end
        end
    end

    // Stage 3: int8 saturation; outputs hold while idle
    logic [7:0]      w_sat;
    logic            out_valid_q;
    logic [7:0]      out_data_q;
    logic [CH_W-1:0] out_ch_q;

    always_comb begin
        if (s2_q > C_SAT_MAX)      w_sat = 8'h7F;
        else if (s2_q < C_SAT_MIN) w_sat = 8'h80;
        else                       w_sat = s2_q[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_data_q <= w_sat;
                out_ch_q   <= ch2_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_requant_int8.sv
`default_nettype none
// ============================================================================
// tb_acc_requant_int8 : table-driven scoreboard bench for acc_requant_int8
// Revision 1.0
// ============================================================================
module tb_acc_requant_int8;
    localparam int NUM_CH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] acc;
        logic        fs;
        logic [7:0]  ed;
        logic [3:0]  ec;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] c;
        int         cyc;
    } exp_t;

    exp_t q[$];

    acc_requant_int8_if #(.NUM_CH(NUM_CH), .ACC_W(32), .MULT_W(16)) bus();

    acc_requant_int8 #(.NUM_CH(NUM_CH), .ACC_W(32), .MULT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got out_valid=1 data=%0d ch=%0d, required no output",
                         $signed(bus.out_data), bus.out_ch);
            end else begin
                e = q.pop_front();
                if (bus.out_data !== e.d || bus.out_ch !== e.c || (cyc - e.cyc) != 3) begin
                    errors++;
                    $display("FAIL result: got data=%0d ch=%0d latency=%0d, required data=%0d ch=%0d latency=3",
                             $signed(bus.out_data), bus.out_ch, cyc - e.cyc, $signed(e.d), e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] acc, input logic fs,
                         input logic we, input logic [3:0] addr, input logic [15:0] m,
                         input logic [4:0] sh, input logic [7:0] zp,
                         input logic push, input logic [7:0] ed, input logic [3:0] ec);
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.in_acc      = acc;
        bus.frame_start = fs;
        bus.cfg_we      = we;
        bus.cfg_addr    = addr;
        bus.cfg_mult    = m;
        bus.cfg_shift   = sh;
        bus.cfg_zp      = zp;
        if (push) q.push_back('{ed, ec, cyc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic [3:0] addr, input logic [15:0] m, input logic [4:0] sh, input logic [7:0] zp);
        drive(0, 0, 0, 1, addr, m, sh, zp, 0, 0, 0);
    endtask

    task automatic sample(input vec_t v);
        drive(1, v.acc, v.fs, 0, 0, 0, 0, 0, 1, v.ed, v.ec);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check(name, q.size(), 0);
    endtask

    vec_t v_def[4], v_rnd[5], v_sat[3], v_fs[8];

    initial begin
        v_def = '{'{32'd5, 1'b0, 8'd5, 4'd0}, '{-32'sd7, 1'b0, -8'sd7, 4'd1},
                  '{32'd300, 1'b0, 8'd127, 4'd2}, '{-32'sd300, 1'b0, 8'h80, 4'd3}};
        v_rnd = '{'{32'd3, 1'b1, 8'd2, 4'd0}, '{-32'sd3, 1'b1, -8'sd1, 4'd0},
                  '{32'd4, 1'b1, 8'd2, 4'd0}, '{-32'sd5, 1'b1, -8'sd2, 4'd0},
                  '{32'd0, 1'b1, 8'd0, 4'd0}};
        v_sat = '{'{32'd130, 1'b1, 8'd125, 4'd0}, '{-32'sd125, 1'b1, 8'h80, 4'd0},
                  '{32'd140, 1'b1, 8'd127, 4'd0}};
        v_fs  = '{'{32'd20, 1'b1, 8'd20, 4'd0}, '{32'd21, 1'b0, 8'd21, 4'd1},
                  '{32'd22, 1'b0, 8'd22, 4'd2}, '{32'd23, 1'b0, 8'd23, 4'd3},
                  '{32'd24, 1'b0, 8'd24, 4'd4}, '{32'd25, 1'b1, 8'd25, 4'd0},
                  '{32'd26, 1'b0, 8'd26, 4'd1}, '{32'd27, 1'b0, 8'd27, 4'd2}};

        bus.in_valid = 0; bus.in_acc = 0; bus.frame_start = 0;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_mult = 0; bus.cfg_shift = 0; bus.cfg_zp = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_data", 32'(bus.out_data), 0);
        check("reset_out_ch", 32'(bus.out_ch), 0);
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 4; i++) sample(v_def[i]);
        idle(1);
        drain("drain_defaults");

        cfg(0, 16'h4000, 5'd15, 8'd0);
        for (int i = 0; i < 5; i++) sample(v_rnd[i]);
        idle(1);
        drain("drain_rounding");

        cfg(0, 16'd1, 5'd0, -8'sd5);
        for (int i = 0; i < 3; i++) sample(v_sat[i]);
        idle(1);
        drain("drain_zp_sat");

        cfg(0, 16'd1, 5'd0, 8'd0);
        for (int i = 0; i < 18; i++) begin
            vec_t v;
            v = '{32'(i + 1), (i == 0), 8'(i + 1), 4'(i % NUM_CH)};
            sample(v);
        end
        idle(1);
        drain("drain_wrap");

        for (int i = 0; i < 8; i++) sample(v_fs[i]);
        idle(1);
        drain("drain_frame_start");

        // Write mult=2 to ch0 in the same cycle as a ch0 sample
        drive(1, 32'd10, 1, 1, 4'd0, 16'd2, 5'd0, 8'd0, 1, 8'd10, 4'd0);
        idle(2);
        sample('{32'd10, 1'b1, 8'd20, 4'd0});
        idle(5);
        drain("drain_collision");
        check("hold_out_data", 32'(bus.out_data), 32'd20);
        check("hold_out_ch", 32'(bus.out_ch), 0);

        // Reset with samples in flight: none of them may emerge
        drive(1, 32'd100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'd101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 32'd102, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 0;
        bus.in_valid = 0;
        #1;
        check("midreset_out_valid", 32'(bus.out_valid), 0);
        check("midreset_out_data", 32'(bus.out_data), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        idle(6);
        sample('{32'd9, 1'b0, 8'd9, 4'd0});
        idle(1);
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_requant_int8.md
# acc_requant_int8

Per-channel requantization stage that converts signed 32-bit convolution accumulators into the signed int8 activation codes consumed by the SELU LUT activation stage. It applies a per-channel fixed-point multiplier, a rounding right shift and a zero-point offset, then saturates to int8. It sits between the MAC array output and the activation stage, and its out_valid/out_data drive the activation stage's in_valid/in_data directly. It is a 3-stage valid-only pipeline with an internal channel sequencer and a small per-channel parameter register file.

## Interface
- NUM_CH, 16: number of output channels; channel counter and parameter file depth.
- ACC_W, 32: signed accumulator input width.
- MULT_W, 16: unsigned multiplier width.
- CH_W, $clog2(NUM_CH): channel index width.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_we  input  1  parameter write strobe.
- cfg_addr  input  CH_W  channel to write.
- cfg_mult  input  MULT_W  unsigned multiplier.
- cfg_shift  input  5  right shift, 0..31.
- cfg_zp  input  8  signed zero-point.
- frame_start  input  1  restarts the channel sequence at channel 0.
- in_valid  input  1  accumulator sample valid.
- in_acc  input  ACC_W  signed accumulator.
- out_valid  output  1  result valid.
- out_data  output  8  signed int8 result, feeds the activation stage.
- out_ch  output  CH_W  channel of out_data.

## Operation
- Parameter file: NUM_CH entries of {mult, shift, zp}. The reset value of every entry is mult=1, shift=0, zp=0, which is saturating passthrough.
- Config write: on cfg_we, entry cfg_addr is written at the clock edge. A cfg_addr value of NUM_CH or above is ignored.
- Channel sequencer (ch, CH_W bits, reset 0):
  - Sample channel: each in_valid sample uses channel cur = frame_start ? 0 : ch.
  - Advance: on each in_valid, ch <= (cur == NUM_CH-1) ? 0 : cur+1.
  - frame_start without in_valid sets ch <= 0.
  - Without in_valid or frame_start, ch holds.
- Stage 1:
  - Parameters: latch cur's entry.
  - Product: p = in_acc × {1'b0, mult}, signed, ACC_W+MULT_W+1 = 49 bits.
- Stage 2:
  - Rounding: r = shift==0 ? p : (p + (1 << (shift-1))) >>> shift. This is an arithmetic shift, rounding half toward +inf, computed at 49 bits with no overflow.
  - Offset: s = r + sign_extend(zp), computed at 50 bits.
- Stage 3:
  - Saturation: out_data = s > 127 ? 127 : s < -128 ? -128 : s[7:0].
  - out_ch carries cur.
- Config/data collision: a sample accepted in the same cycle as a write to its channel uses the old parameters. Samples accepted from the next cycle onward use the new parameters. Parameters are captured at stage 1, so in-flight samples are unaffected by later writes.

## Timing
- Latency: exactly 3 cycles from in_valid to out_valid.
- Throughput: one sample per cycle; back-to-back samples are accepted with no bubbles.
- Flow control: none. There is no ready signal and the downstream stage always accepts.
- Output hold: out_data and out_ch change only on cycles where out_valid rises or stays high, and hold their last value when out_valid=0.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - Pipeline valid bits are 0, ch=0, and all parameter entries are at their defaults.
- Reset mid-operation: all in-flight samples are discarded with no spurious out_valid, and the first valid output after reset appears 3 cycles after the first post-reset in_valid.
- Simultaneous events:
  - frame_start with in_valid: the sample is channel 0 and ch becomes 1 (0 if NUM_CH=1).
  - cfg_we with in_valid: handled as stated under Operation.

## Test plan
- Defaults after reset:
  - in_acc = 5, -7, 300, -300 → out_data = 5, -7, 127, -128.
  - out_valid rises 3 cycles after each input; out_ch = 0, 1, 2, 3.
- Rounding, with ch0 mult=0x4000, shift=15, zp=0:
  - in_acc = 3 → 2; -3 → -1; 4 → 2; -5 → -2; 0 → 0.
- Zero-point and saturation, with ch0 mult=1, shift=0, zp=-5:
  - in_acc = 130 → 125; -125 → -128; 140 → 127.
- Wrap and frame_start, with NUM_CH=16:
  - 18 back-to-back samples → out_ch = 0..15, 0, 1.
  - frame_start with the 6th sample → that sample has out_ch=0 and the next has out_ch=1.
- Config collision, with ch0 mult=1 and samples on ch0 each frame:
  - Write mult=2 to ch0 in the same cycle as a ch0 sample with in_acc=10 → 10.
  - Next frame's ch0 sample with in_acc=10 → 20.
- Reset mid-stream:
  - Assert rst_n low with 3 samples in flight → no out_valid during or after reset.
  - ch returns to 0 and parameters return to defaults.
  - Next sample in_acc=9 → out_data=9 and out_ch=0 after 3 cycles.
